dllp_ack_nak_gen: RTL and testbench



---
 rtl/dllp_ack_nak_gen.sv | 205 ++++++++++++++++++++
 tb/tb_dllp_ack_nak_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dllp_ack_nak_gen.sv
// Receive-side Ack/Nak responder: tracks NEXT_RCV_SEQ, classifies incoming TLPs and
// emits Ack/Nak DLLPs (with CRC16) as a two-beat AXI-Stream packet.
module dllp_ack_nak_gen #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int                    USER_WIDTH   = 3,
  parameter logic [USER_WIDTH-1:0] DLLP_TUSER   = 3'b001,
  parameter int                    ACK_LATENCY  = 64,
  parameter int                    ACK_COALESCE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  link_active_i,
  input  logic                  rx_seq_vld_i,
  input  logic [11:0]           rx_seq_num_i,
  input  logic                  rx_lcrc_ok_i,
  output logic                  rx_tlp_accept_o,
  output logic                  rx_tlp_drop_o,
  output logic [11:0]           next_rcv_seq_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("dllp_ack_nak_gen: only DATA_WIDTH=32 is supported");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;

  localparam int TW = (ACK_LATENCY > 1) ? $clog2(ACK_LATENCY) : 1;
  localparam int CW = $clog2(ACK_COALESCE + 1);
  localparam logic [TW-1:0] TIMER_MAX    = TW'(ACK_LATENCY - 1);
  localparam logic [CW-1:0] COALESCE_MAX = CW'(ACK_COALESCE);
  localparam logic [7:0]    TYPE_ACK     = 8'h00;
  localparam logic [7:0]    TYPE_NAK     = 8'h10;

  logic [1:0]    state_q, state_d;
  logic [11:0]   nrs_q, nrs_d;
  logic          nakSched_q, nakSched_d;
  logic          ackPend_q, ackPend_d;
  logic          nakPend_q, nakPend_d;
  logic          dupSeen_q, dupSeen_d;
  logic [CW-1:0] pendCnt_q, pendCnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   beat0_q, beat0_d;
  logic          accept_q, accept_d;
  logic          drop_q, drop_d;

  logic [11:0] seqDist;
  logic [11:0] ackSeq;
  logic        evValid, evBad, evAccept, evDup, evAhead;
  logic        ackTrig, nakTrig, launch;
  logic [15:0] crcTx;

  // DLLP CRC: bytes 0..3 in order, bit 7 of each byte first; inverted result is
  // bit-reversed so CRC bit 15 lands in bit 0 of the first CRC byte on the wire.
  function automatic logic [15:0] dllpCrc(input logic [31:0] w);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ w[8*i + b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
      end
    end
    c = ~c;
    for (int j = 0; j < 16; j++) begin
      r[j] = c[15 - j];
    end
    return r;
  endfunction

  assign seqDist  = nrs_q - rx_seq_num_i;
  assign ackSeq   = nrs_q - 12'd1;
  assign evValid  = rx_seq_vld_i & link_active_i;
  assign evBad    = evValid & ~rx_lcrc_ok_i;
  assign evAccept = evValid & rx_lcrc_ok_i & (seqDist == 12'd0);
  assign evDup    = evValid & rx_lcrc_ok_i & (seqDist != 12'd0) & (seqDist <= 12'd2048);
  assign evAhead  = evValid & rx_lcrc_ok_i & (seqDist > 12'd2048);

  assign ackTrig = ackPend_q & ((timer_q == TIMER_MAX) | (pendCnt_q >= COALESCE_MAX) | dupSeen_q);
  assign nakTrig = nakPend_q;
  assign launch  = (state_q == ST_IDLE) & (ackTrig | nakTrig);

  // Launch samples the current state first; a same-cycle event is layered on top.
  always_comb begin
    state_d    = state_q;
    nrs_d      = nrs_q;
    nakSched_d = nakSched_q;
    ackPend_d  = ackPend_q;
    nakPend_d  = nakPend_q;
    dupSeen_d  = dupSeen_q;
    pendCnt_d  = pendCnt_q;
    timer_d    = timer_q;
    beat0_d    = beat0_q;

    case (state_q)
      ST_IDLE:  if (launch) state_d = ST_BEAT0;
      ST_BEAT0: if (m_axis_tready) state_d = ST_BEAT1;
      ST_BEAT1: if (m_axis_tready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (!ackPend_q) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + 1'b1;
    end

    if (launch) begin
      beat0_d   = {ackSeq[7:0], 4'h0, ackSeq[11:8], 8'h00, nakTrig ? TYPE_NAK : TYPE_ACK};
      ackPend_d = 1'b0;
      dupSeen_d = 1'b0;
      pendCnt_d = '0;
      timer_d   = '0;
      if (nakTrig) nakPend_d = 1'b0;
    end

    if ((evBad | evAhead) && !nakSched_q) begin
      nakPend_d  = 1'b1;
      nakSched_d = 1'b1;
    end
    if (evAccept) begin
      nrs_d      = nrs_q + 12'd1;
      nakSched_d = 1'b0;
      ackPend_d  = 1'b1;
      if (pendCnt_d != COALESCE_MAX) pendCnt_d = pendCnt_d + 1'b1;
    end
    if (evDup) begin
      ackPend_d = 1'b1;
      dupSeen_d = 1'b1;
    end
  end

  assign accept_d = evAccept;
  assign drop_d   = evValid & ~evAccept;

  // Link down behaves exactly like reset, including abandoning a DLLP in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i || !link_active_i) begin
      state_q    <= ST_IDLE;
      nrs_q      <= '0;
      nakSched_q <= 1'b0;
      ackPend_q  <= 1'b0;
      nakPend_q  <= 1'b0;
      dupSeen_q  <= 1'b0;
      pendCnt_q  <= '0;
      timer_q    <= '0;
      beat0_q    <= '0;
      accept_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nrs_q      <= nrs_d;
      nakSched_q <= nakSched_d;
      ackPend_q  <= ackPend_d;
      nakPend_q  <= nakPend_d;
      dupSeen_q  <= dupSeen_d;
      pendCnt_q  <= pendCnt_d;
      timer_q    <= timer_d;
      beat0_q    <= beat0_d;
      accept_q   <= accept_d;
      drop_q     <= drop_d;
    end
  end

  assign crcTx = dllpCrc(beat0_q);

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tuser  = '0;
    case (state_q)
      ST_BEAT0: begin
        m_axis_tdata  = beat0_q;
        m_axis_tkeep  = 4'hF;
        m_axis_tvalid = 1'b1;
        m_axis_tuser  = DLLP_TUSER;
      end
      ST_BEAT1: begin
        m_axis_tdata  = {16'h0000, crcTx};
        m_axis_tkeep  = 4'h3;
        m_axis_tlast  = 1'b1;
        m_axis_tvalid = 1'b1;
        m_axis_tuser  = DLLP_TUSER;
      end
      default: ;
    endcase
  end

  assign rx_tlp_accept_o = accept_q;
  assign rx_tlp_drop_o   = drop_q;
  assign next_rcv_seq_o  = nrs_q;

endmodule

// File: tb/tb_dllp_ack_nak_gen.sv
// Directed bench for dllp_ack_nak_gen: sequence tracking, Ack coalescing/timer,
// Nak scheduling, duplicate handling, sequence wrap, backpressure and link down.
module tb_dllp_ack_nak_gen;

  logic        clk;
  logic        rst;
  logic        linkActive;
  logic        rxSeqVld;
  logic [11:0] rxSeqNum;
  logic        rxLcrcOk;
  logic        rxAccept;
  logic        rxDrop;
  logic [11:0] nextRcvSeq;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic [2:0]  tuser;
  logic        tready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          startCyc;
    logic [31:0] d0;
    logic [3:0]  k0;
    logic        l0;
    logic [2:0]  u;
    logic [31:0] d1;
    logic [3:0]  k1;
    logic        l1;
  } dllp_t;

  dllp_t dllpQ[$];

  dllp_ack_nak_gen dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .link_active_i   (linkActive),
    .rx_seq_vld_i    (rxSeqVld),
    .rx_seq_num_i    (rxSeqNum),
    .rx_lcrc_ok_i    (rxLcrcOk),
    .rx_tlp_accept_o (rxAccept),
    .rx_tlp_drop_o   (rxDrop),
    .next_rcv_seq_o  (nextRcvSeq),
    .m_axis_tdata    (tdata),
    .m_axis_tkeep    (tkeep),
    .m_axis_tvalid   (tvalid),
    .m_axis_tlast    (tlast),
    .m_axis_tuser    (tuser),
    .m_axis_tready   (tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Packet monitor samples on the falling edge, when inputs and outputs are settled.
  logic        inPkt = 1'b0;
  logic        seenValid = 1'b0;
  int          startQ = 0;
  logic [31:0] d0Q = '0;
  logic [3:0]  k0Q = '0;
  logic        l0Q = 1'b0;
  logic [2:0]  uQ = '0;

  always @(negedge clk) begin
    if (rst || !linkActive) begin
      inPkt     <= 1'b0;
      seenValid <= 1'b0;
    end else if (tvalid) begin
      if (!seenValid) begin
        startQ    <= cyc;
        seenValid <= 1'b1;
      end
      if (tready) begin
        if (!inPkt) begin
          d0Q   <= tdata;
          k0Q   <= tkeep;
          l0Q   <= tlast;
          uQ    <= tuser;
          inPkt <= 1'b1;
        end else begin
          dllpQ.push_back('{startQ, d0Q, k0Q, l0Q, uQ, tdata, tkeep, tlast});
          inPkt     <= 1'b0;
          seenValid <= 1'b0;
        end
      end
    end
  end

  // Reference CRC: serial bit stream, byte 0 first, bit 7 of each byte first.
  function automatic logic [31:0] crcBeat(input logic [31:0] w);
    logic [15:0] r;
    logic [31:0] res;
    logic        fbIn;
    r = 16'hFFFF;
    for (int n = 0; n < 32; n++) begin
      fbIn = w[(n / 8) * 8 + 7 - (n % 8)];
      if (r[15] ^ fbIn) r = (r << 1) ^ 16'h100B;
      else              r = r << 1;
    end
    r   = ~r;
    res = '0;
    for (int j = 0; j < 16; j++) res[j] = r[15 - j];
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] s, input logic ok);
    rxSeqVld = 1'b1;
    rxSeqNum = s;
    rxLcrcOk = ok;
    @(posedge clk); #1;
    rxSeqVld = 1'b0;
    rxLcrcOk = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dllpQ.delete();
  endtask

  task automatic checkDllp(input string tag, input int idx, input logic [31:0] expD0);
    checkOutput({tag, " beat0"}, dllpQ[idx].d0, expD0);
    checkOutput({tag, " keep0"}, 32'(dllpQ[idx].k0), 32'hF);
    checkOutput({tag, " last0"}, 32'(dllpQ[idx].l0), 32'h0);
    checkOutput({tag, " tuser"}, 32'(dllpQ[idx].u), 32'h1);
    checkOutput({tag, " beat1 crc"}, dllpQ[idx].d1, crcBeat(expD0));
    checkOutput({tag, " keep1"}, 32'(dllpQ[idx].k1), 32'h3);
    checkOutput({tag, " last1"}, 32'(dllpQ[idx].l1), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    rst        = 1'b1;
    linkActive = 1'b1;
    rxSeqVld   = 1'b0;
    rxSeqNum   = '0;
    rxLcrcOk   = 1'b1;
    tready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("reset tvalid", 32'(tvalid), 32'h0);
    checkOutput("reset tdata", tdata, 32'h0);
    checkOutput("reset nrs", 32'(nextRcvSeq), 32'h0);
    checkOutput("reset accept", 32'(rxAccept), 32'h0);
    checkOutput("reset drop", 32'(rxDrop), 32'h0);
    rst = 1'b0;
    dllpQ.delete();

    $display("[TB] three in-order TLPs, Ack on timer");
    applyStimulus(12'd0, 1'b1);
    t0 = cyc;
    checkOutput("s1 accept", 32'(rxAccept), 32'h1);
    checkOutput("s1 drop", 32'(rxDrop), 32'h0);
    checkOutput("s1 nrs after 1", 32'(nextRcvSeq), 32'd1);
    applyStimulus(12'd1, 1'b1);
    applyStimulus(12'd2, 1'b1);
    checkOutput("s1 nrs after 3", 32'(nextRcvSeq), 32'd3);
    waitCycles(1);
    checkOutput("s1 accept is one pulse", 32'(rxAccept), 32'h0);
    waitCycles(70);
    checkOutput("s1 dllp count", 32'(dllpQ.size()), 32'd1);
    checkOutput("s1 ack latency", 32'(dllpQ[0].startCyc - t0), 32'd64);
    checkDllp("s1 ack", 0, 32'h0200_0000);

    $display("[TB] four TLPs force coalesced Ack");
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(12'(i), 1'b1);
    t0 = cyc;
    checkOutput("s2 nrs", 32'(nextRcvSeq), 32'd4);
    waitCycles(6);
    checkOutput("s2 dllp count", 32'(dllpQ.size()), 32'd1);
    checkOutput("s2 ack start", 32'(dllpQ[0].startCyc - t0), 32'd1);
    checkDllp("s2 ack", 0, 32'h0300_0000);

    $display("[TB] bad LCRC then out-of-order gives one Nak");
    resetDut();
    applyStimulus(12'd0, 1'b1);
    applyStimulus(12'd1, 1'b0);
    checkOutput("s3 bad drop", 32'(rxDrop), 32'h1);
    checkOutput("s3 bad accept", 32'(rxAccept), 32'h0);
    checkOutput("s3 nrs held", 32'(nextRcvSeq), 32'd1);
    applyStimulus(12'd2, 1'b1);
    checkOutput("s3 ahead drop", 32'(rxDrop), 32'h1);
    waitCycles(10);
    checkOutput("s3 dllp count", 32'(dllpQ.size()), 32'd1);
    checkDllp("s3 nak", 0, 32'h0000_0010);
    waitCycles(20);
    checkOutput("s3 no second nak", 32'(dllpQ.size()), 32'd1);
    applyStimulus(12'd1, 1'b1);
    checkOutput("s3 retry accept", 32'(rxAccept), 32'h1);
    checkOutput("s3 retry nrs", 32'(nextRcvSeq), 32'd2);
    applyStimulus(12'd5, 1'b0);
    waitCycles(10);
    checkOutput("s3 nak rearmed count", 32'(dllpQ.size()), 32'd2);
    checkOutput("s3 nak rearmed beat0", dllpQ[1].d0, 32'h0100_0010);

    $display("[TB] duplicates and the 2048 boundary");
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(12'(i), 1'b1);
    waitCycles(10);
    checkOutput("s4 first ack count", 32'(dllpQ.size()), 32'd1);
    checkOutput("s4 first ack beat0", dllpQ[0].d0, 32'h0300_0000);
    applyStimulus(12'd3, 1'b1);
    t0 = cyc;
    checkOutput("s4 dup drop", 32'(rxDrop), 32'h1);
    checkOutput("s4 dup accept", 32'(rxAccept), 32'h0);
    checkOutput("s4 dup nrs", 32'(nextRcvSeq), 32'd5);
    waitCycles(6);
    checkOutput("s4 dup ack count", 32'(dllpQ.size()), 32'd2);
    checkOutput("s4 dup ack start", 32'(dllpQ[1].startCyc - t0), 32'd1);
    checkDllp("s4 dup ack", 1, 32'h0400_0000);
    applyStimulus(12'd2053, 1'b1);
    checkOutput("s4 d2048 drop", 32'(rxDrop), 32'h1);
    waitCycles(6);
    checkOutput("s4 d2048 count", 32'(dllpQ.size()), 32'd3);
    checkOutput("s4 d2048 is ack", dllpQ[2].d0, 32'h0400_0000);
    applyStimulus(12'd2052, 1'b1);
    checkOutput("s4 d2049 drop", 32'(rxDrop), 32'h1);
    waitCycles(6);
    checkOutput("s4 d2049 count", 32'(dllpQ.size()), 32'd4);
    checkOutput("s4 d2049 is nak", dllpQ[3].d0, 32'h0400_0010);

    $display("[TB] sequence number wrap");
    resetDut();
    for (int i = 0; i < 4095; i++) applyStimulus(12'(i), 1'b1);
    checkOutput("s5 nrs 4095", 32'(nextRcvSeq), 32'd4095);
    waitCycles(80);
    dllpQ.delete();
    applyStimulus(12'd4095, 1'b1);
    checkOutput("s5 wrap accept", 32'(rxAccept), 32'h1);
    checkOutput("s5 wrap nrs", 32'(nextRcvSeq), 32'd0);
    waitCycles(70);
    checkOutput("s5 wrap count", 32'(dllpQ.size()), 32'd1);
    checkDllp("s5 wrap ack", 0, 32'hFF0F_0000);

    $display("[TB] backpressure and link down");
    resetDut();
    applyStimulus(12'd0, 1'b1);
    applyStimulus(12'd1, 1'b1);
    tready = 1'b0;
    applyStimulus(12'd9, 1'b0);
    checkOutput("s6 bad drop", 32'(rxDrop), 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (tvalid) break;
      waitCycles(1);
    end
    checkOutput("s6 tvalid up", 32'(tvalid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("s6 stall beat0", tdata, 32'h0100_0010);
      checkOutput("s6 stall tlast", 32'(tlast), 32'h0);
      waitCycles(1);
    end
    tready = 1'b1;
    waitCycles(1);
    tready = 1'b0;
    checkOutput("s6 beat1 tlast", 32'(tlast), 32'h1);
    checkOutput("s6 beat1 tkeep", 32'(tkeep), 32'h3);
    checkOutput("s6 beat1 crc", tdata, crcBeat(32'h0100_0010));
    linkActive = 1'b0;
    waitCycles(1);
    checkOutput("s6 link down tvalid", 32'(tvalid), 32'h0);
    checkOutput("s6 link down nrs", 32'(nextRcvSeq), 32'h0);
    linkActive = 1'b1;
    tready = 1'b1;
    waitCycles(3);
    checkOutput("s6 abandoned not delivered", 32'(dllpQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
